// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the core's decoder:
// access-size encodings and the responder's state encoding.
package dmem_pkg;

    localparam logic [1:0] SIZE_B   = 2'd0;
    localparam logic [1:0] SIZE_H   = 2'd1;
    localparam logic [1:0] SIZE_W   = 2'd2;
    localparam logic [1:0] SIZE_RSV = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one access: store mask and replicated store data,
// plus load-data alignment with sign/zero extension and an alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdataRep,
    output logic [31:0] o_rdataExt,
    output logic        o_misalign
);

    logic [31:0] w_shifted;

    // Reserved size yields an empty mask and no data; the caller flags it as an error.
    always_comb begin
        w_shifted  = i_rword >> {i_lane, 3'b000};
        o_mask     = 4'b0000;
        o_wdataRep = i_wdata;
        o_rdataExt = '0;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_B: begin
                o_mask     = 4'b0001 << i_lane;
                o_wdataRep = {4{i_wdata[7:0]}};
                o_rdataExt = i_unsigned ? {24'b0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SIZE_H: begin
                o_mask     = 4'b0011 << i_lane;
                o_wdataRep = {2{i_wdata[15:0]}};
                o_rdataExt = i_unsigned ? {16'b0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
                o_misalign = i_lane[0];
            end
            SIZE_W: begin
                o_mask     = 4'b1111;
                o_wdataRep = i_wdata;
                o_rdataExt = w_shifted;
                o_misalign = (i_lane != 2'b00);
            end
            default: begin
                o_mask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time over valid/ready,
// LATENCY wait cycles, one access cycle, then a held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDXW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_LOAD   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_rspValid;
    logic [31:0] r_rspRdata;
    logic        r_rspErr;
    logic [31:0] r_mem [DEPTH];

    logic [3:0]      w_mask;
    logic [31:0]     w_wdataRep;
    logic [31:0]     w_rdataExt;
    logic            w_misalign;
    logic            w_outOfRange;
    logic            w_err;
    logic            w_doWrite;
    logic [31:0]     w_rword;
    logic [IDXW-1:0] w_wordIdx;

    // The full 32-bit address is range-checked so high addresses never alias low words.
    assign w_wordIdx    = r_addr[IDXW+1:2];
    assign w_outOfRange = ({1'b0, r_addr} >= ADDR_LIMIT);
    assign w_err        = w_misalign | (r_size == SIZE_RSV) | w_outOfRange;
    assign w_rword      = w_outOfRange ? 32'd0 : r_mem[w_wordIdx];
    assign w_doWrite    = (r_state == ACCESS) && r_we && !w_err;

    dmem_lane_align u_align (
        .i_size     (r_size),
        .i_lane     (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_mask     (w_mask),
        .o_wdataRep (w_wdataRep),
        .o_rdataExt (w_rdataExt),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) begin
                    r_mem[w_wordIdx][8*b +: 8] <= w_wdataRep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_size     <= SIZE_B;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata;
                        if (LATENCY == 0) begin
                            r_state <= ACCESS;
                        end else begin
                            r_count <= CNT_LOAD;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state <= ACCESS;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ACCESS: begin
                    r_rspErr   <= w_err;
                    r_rspRdata <= (w_err || r_we) ? 32'd0 : w_rdataExt;
                    r_rspValid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with LATENCY=2: data path, lane steering,
// error cases, response back-pressure and reset during a pending store.
module tb_dmem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_R = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents a request at a falling edge and returns just after the accepting rising edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata);
        int waitCycles = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        while (!req_ready && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) begin
            checkOutput("accept timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    // Counts rising edges after the accept edge until rsp_valid is seen, bounded.
    task automatic waitResponse(output logic [31:0] rdata, output logic err, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            #1;
        end while (!rsp_valid && cycles < 20);
        if (!rsp_valid) checkOutput("response timeout", {31'b0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic doAccess(input string tag, input logic we, input logic [31:0] addr,
                            input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                            input logic [31:0] expRdata, input logic expErr);
        logic [31:0] rdata;
        logic        err;
        int          cycles;
        applyStimulus(we, addr, size, uns, wdata);
        waitResponse(rdata, err, cycles);
        checkOutput({tag, " latency"}, cycles, LATENCY + 1);
        checkOutput({tag, " rdata"}, rdata, expRdata);
        checkOutput({tag, " err"}, {31'b0, err}, {31'b0, expErr});
        @(posedge clk);
        #1;
        checkOutput({tag, " valid drop"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          cycles;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post-reset req_ready", {31'b0, req_ready}, 32'd1);

        doAccess("SW 10", 1'b1, 32'h10, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        doAccess("LW 10", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        doAccess("SB 13", 1'b1, 32'h13, SZ_B, 1'b0, 32'h0000005A, 32'h0, 1'b0);
        doAccess("LW 10 after SB", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h5AADBEEF, 1'b0);
        doAccess("LB 13", 1'b0, 32'h13, SZ_B, 1'b0, 32'h0, 32'h0000005A, 1'b0);
        doAccess("LB 12", 1'b0, 32'h12, SZ_B, 1'b0, 32'h0, 32'hFFFFFFAD, 1'b0);
        doAccess("LBU 12", 1'b0, 32'h12, SZ_B, 1'b1, 32'h0, 32'h000000AD, 1'b0);
        doAccess("LH 12", 1'b0, 32'h12, SZ_H, 1'b0, 32'h0, 32'h00005AAD, 1'b0);
        doAccess("LH 10", 1'b0, 32'h10, SZ_H, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
        doAccess("LHU 10", 1'b0, 32'h10, SZ_H, 1'b1, 32'h0, 32'h0000BEEF, 1'b0);

        doAccess("SW 30 clear", 1'b1, 32'h30, SZ_W, 1'b0, 32'h00000000, 32'h0, 1'b0);
        doAccess("SH 32", 1'b1, 32'h32, SZ_H, 1'b0, 32'h0000CAFE, 32'h0, 1'b0);
        doAccess("SB 31", 1'b1, 32'h31, SZ_B, 1'b0, 32'h00000077, 32'h0, 1'b0);
        doAccess("LW 30", 1'b0, 32'h30, SZ_W, 1'b0, 32'h0, 32'hCAFE7700, 1'b0);

        doAccess("LH 11 misaligned", 1'b0, 32'h11, SZ_H, 1'b0, 32'h0, 32'h0, 1'b1);
        doAccess("SW 12 misaligned", 1'b1, 32'h12, SZ_W, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        doAccess("LW 10 after bad SW", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h5AADBEEF, 1'b0);
        doAccess("size 3", 1'b0, 32'h10, SZ_R, 1'b0, 32'h0, 32'h0, 1'b1);

        doAccess("SW last word", 1'b1, DEPTH*4 - 4, SZ_W, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0);
        doAccess("LW last word", 1'b0, DEPTH*4 - 4, SZ_W, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);
        doAccess("LW out of range", 1'b0, DEPTH*4, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1);
        doAccess("SW 0 clear", 1'b1, 32'h0, SZ_W, 1'b0, 32'h00000000, 32'h0, 1'b0);
        doAccess("SW out of range", 1'b1, DEPTH*4, SZ_W, 1'b0, 32'h11111111, 32'h0, 1'b1);
        doAccess("LW 0 no alias", 1'b0, 32'h0, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0);

        // Back-pressure: the response must hold while a competing request is ignored.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
        waitResponse(rdata, err, cycles);
        checkOutput("stall first rdata", rdata, 32'h5AADBEEF);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_size  = SZ_W;
        req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("stall rsp_rdata", rsp_rdata, 32'h5AADBEEF);
            checkOutput("stall rsp_err", {31'b0, rsp_err}, 32'd0);
            checkOutput("stall req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("release req_ready", {31'b0, req_ready}, 32'd1);
        doAccess("LW 10 after stall", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h5AADBEEF, 1'b0);

        // Reset while a store sits in WAIT must discard the store.
        doAccess("SW 20 preload", 1'b1, 32'h20, SZ_W, 1'b0, 32'h00000000, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h20, SZ_W, 1'b0, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst mid rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst mid req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("after rst req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("after rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("after rst rsp_rdata", rsp_rdata, 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("idle rsp_valid", {31'b0, rsp_valid}, 32'd0);
        doAccess("LW 20 after rst", 1'b0, 32'h20, SZ_W, 1'b0, 32'h0, 32'h00000000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
